// File: rtl/rcpu_irq_ctrl.sv
// rtl/rcpu_irq_ctrl.sv - 8-source prioritised interrupt controller with vectored request/ack handshake.
// Define RCPU_IRQ_LEVEL_EN for level-sensitive PENDING; the default build latches synchronised rising edges.
module rcpu_irq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  src,
  input  logic        cfgWE,
  input  logic [1:0]  cfgAddr,
  input  logic [15:0] cfgWData,
  output logic [15:0] cfgRData,
  output logic        irq,
  input  logic        turnOffIRQ,
  output logic [31:0] intAddr,
  output logic [15:0] intData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [2:0]  id;
  logic [2:0]  idNext;
  logic        irqNext;
  logic [31:0] intAddrNext;
  logic [15:0] intDataNext;

  logic [7:0]  syncA;
  logic [7:0]  syncB;
  logic [7:0]  mask;
  logic [15:0] vecBase;
  logic [7:0]  pending;
  logic [7:0]  active;
  logic [2:0]  prioId;

  logic        maskWr;
  logic        vecWr;

  assign maskWr = cfgWE && (cfgAddr == 2'd0);
  assign vecWr  = cfgWE && (cfgAddr == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= src;
      syncB <= syncA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask    <= '0;
      vecBase <= 16'hF000;
    end else begin
      if (maskWr) mask <= cfgWData[7:0];
      if (vecWr)  vecBase <= cfgWData;
    end
  end

`ifdef RCPU_IRQ_LEVEL_EN
  assign pending = syncB;
`else
  logic [7:0] srcPrev;
  logic [7:0] edgeSet;
  logic [7:0] pendSet;
  logic [7:0] pendClr;
  logic       pendWr;
  logic       swSetWr;

  assign pendWr  = cfgWE && (cfgAddr == 2'd1);
  assign swSetWr = cfgWE && (cfgAddr == 2'd3);
  assign edgeSet = syncB & ~srcPrev;

  // Sources are OR-ed in after clears so a coincident set always survives.
  always_comb begin
    pendSet = edgeSet;
    pendClr = '0;
    if (swSetWr) pendSet = pendSet | cfgWData[7:0];
    if (pendWr)  pendClr = cfgWData[7:0];
    if ((state == REQ) && turnOffIRQ) pendClr[id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srcPrev <= '0;
      pending <= '0;
    end else begin
      srcPrev <= syncB;
      pending <= (pending & ~pendClr) | pendSet;
    end
  end
`endif

  assign active = pending & mask;

  always_comb begin
    prioId = '0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) prioId = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      id      <= '0;
      irq     <= 1'b0;
      intAddr <= '0;
      intData <= '0;
    end else begin
      state   <= stateNext;
      id      <= idNext;
      irq     <= irqNext;
      intAddr <= intAddrNext;
      intData <= intDataNext;
    end
  end

  // Outputs are only loaded on the IDLE->REQ transition, so they stay frozen through REQ and HOLD.
  always_comb begin
    stateNext   = state;
    idNext      = id;
    irqNext     = irq;
    intAddrNext = intAddr;
    intDataNext = intData;
    case (state)
      IDLE: begin
        if (|active) begin
          stateNext   = REQ;
          idNext      = prioId;
          irqNext     = 1'b1;
          intAddrNext = {vecBase, 12'h000, prioId, 1'b0};
          intDataNext = {pending, 5'b00000, prioId};
        end
      end
      REQ: begin
        if (turnOffIRQ) begin
          stateNext = HOLD;
          irqNext   = 1'b0;
        end
      end
      HOLD: begin
        if (!turnOffIRQ) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        irqNext   = 1'b0;
      end
    endcase
  end

  always_comb begin
    cfgRData = '0;
    case (cfgAddr)
      2'd0: cfgRData = {8'h00, mask};
      2'd1: cfgRData = {8'h00, pending};
      2'd2: cfgRData = vecBase;
      2'd3: cfgRData = {12'h000, state[0], id};
      default: cfgRData = '0;
    endcase
  end

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// tb/tb_rcpu_irq_ctrl.sv - scoreboard bench for rcpu_irq_ctrl; expected vectors queued at stimulus, popped on irq rise.
module tb_rcpu_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        cfgWE;
  logic [1:0]  cfgAddr;
  logic [15:0] cfgWData;
  logic [15:0] cfgRData;
  logic        irq;
  logic        turnOffIRQ;
  logic [31:0] intAddr;
  logic [15:0] intData;

  int checks = 0;
  int errors = 0;
  logic [47:0] expQ[$];
  logic irqPrev = 1'b0;
  logic [15:0] rd;

  rcpu_irq_ctrl dut (
    .clk(clk), .rst(rst), .src(src), .cfgWE(cfgWE), .cfgAddr(cfgAddr),
    .cfgWData(cfgWData), .cfgRData(cfgRData), .irq(irq), .turnOffIRQ(turnOffIRQ),
    .intAddr(intAddr), .intData(intData)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && irq && !irqPrev) begin
      if (expQ.size() == 0) begin
        checkEq("unexpectedIrq", {31'b0, irq}, 32'd0);
      end else begin
        logic [47:0] e;
        e = expQ.pop_front();
        checkEq("intAddr", intAddr, e[47:16]);
        checkEq("intData", {16'h0, intData}, {16'h0, e[15:0]});
      end
    end
    irqPrev = irq;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
    cfgWE = 1'b1; cfgAddr = a; cfgWData = d;
    @(negedge clk);
    cfgWE = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [15:0] d);
    cfgAddr = a;
    #1;
    d = cfgRData;
  endtask

  task automatic pulse(input logic [7:0] s);
    src = s;
    @(negedge clk);
    src = 8'h00;
  endtask

  task automatic waitIrq(input int budget);
    int n = 0;
    while (!irq && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!irq) checkEq("irqTimeout", {31'b0, irq}, 32'd1);
  endtask

  task automatic ackIrq();
    turnOffIRQ = 1'b1;
    @(negedge clk);
    checkEq("ackIrqLow", {31'b0, irq}, 32'd0);
    turnOffIRQ = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; src = 8'h01; cfgWE = 1'b0; cfgAddr = 2'd0; cfgWData = '0; turnOffIRQ = 1'b0;
    cyc(3);
    checkEq("rstIrq", {31'b0, irq}, 32'd0);
    checkEq("rstAddr", intAddr, 32'd0);
    checkEq("rstData", {16'h0, intData}, 32'd0);
    readReg(2'd0, rd); checkEq("rstMask", {16'h0, rd}, 32'h0);
    readReg(2'd1, rd); checkEq("rstPend", {16'h0, rd}, 32'h0);
    readReg(2'd2, rd); checkEq("rstVec", {16'h0, rd}, 32'hF000);
    readReg(2'd3, rd); checkEq("rstStatus", {16'h0, rd}, 32'h0);

    // src held high through reset gives exactly one edge after release
    @(negedge clk); rst = 1'b1;
    cyc(4);
    readReg(2'd1, rd); checkEq("heldHighEdge", {16'h0, rd}, 32'h01);
    src = 8'h00;
    writeReg(2'd1, 16'h0001);
    readReg(2'd1, rd); checkEq("w1cClear", {16'h0, rd}, 32'h0);

    // Single source latency and ack
    writeReg(2'd0, 16'h0001);
    expQ.push_back({32'hF000_0000, 16'h0100});
    pulse(8'h01);
    cyc(2);
    readReg(2'd1, rd); checkEq("latPend", {16'h0, rd}, 32'h01);
    checkEq("latIrqEarly", {31'b0, irq}, 32'd0);
    @(negedge clk);
    checkEq("latIrq", {31'b0, irq}, 32'd1);
    ackIrq();
    readReg(2'd1, rd); checkEq("ackPend", {16'h0, rd}, 32'h0);

    // Two simultaneous sources: lowest index first
    writeReg(2'd0, 16'h00FF);
    expQ.push_back({32'hF000_0004, 16'h2402});
    expQ.push_back({32'hF000_000A, 16'h2005});
    pulse(8'h24);
    waitIrq(10);
    turnOffIRQ = 1'b1;
    @(negedge clk);
    readReg(2'd1, rd); checkEq("prioPendAfterAck", {16'h0, rd}, 32'h20);
    turnOffIRQ = 1'b0;
    @(negedge clk);
    waitIrq(10);
    ackIrq();

    // Masked pending, then unmask
    writeReg(2'd0, 16'h0000);
    pulse(8'h08);
    cyc(4);
    readReg(2'd1, rd); checkEq("maskedPend", {16'h0, rd}, 32'h08);
    checkEq("maskedIrq", {31'b0, irq}, 32'd0);
    expQ.push_back({32'hF000_0006, 16'h0803});
    writeReg(2'd0, 16'h0008);
    waitIrq(10);
    ackIrq();
    writeReg(2'd0, 16'h0000);
    pulse(8'h08);
    cyc(4);
    writeReg(2'd1, 16'h0008);
    writeReg(2'd0, 16'h0008);
    cyc(3);
    checkEq("clearedNoIrq", {31'b0, irq}, 32'd0);

    // Request frozen while MASK and PENDING change
    writeReg(2'd0, 16'h0002);
    expQ.push_back({32'hF000_0002, 16'h0201});
    pulse(8'h02);
    waitIrq(10);
    readReg(2'd3, rd); checkEq("statusReq", {16'h0, rd}, 32'h0009);
    writeReg(2'd0, 16'h0000);
    pulse(8'h01);
    cyc(4);
    checkEq("holdIrq", {31'b0, irq}, 32'd1);
    checkEq("holdData", {16'h0, intData}, 32'h0201);
    checkEq("holdAddr", intAddr, 32'hF000_0002);
    ackIrq();
    readReg(2'd3, rd); checkEq("statusIdle", {16'h0, rd}, 32'h0001);
    readReg(2'd1, rd); checkEq("pendAfterFreeze", {16'h0, rd}, 32'h01);
    writeReg(2'd1, 16'h0001);

    // Edge on the same cycle as ack of the same id: set wins
    writeReg(2'd0, 16'h0010);
    expQ.push_back({32'hF000_0008, 16'h1004});
    expQ.push_back({32'hF000_0008, 16'h1004});
    pulse(8'h10);
    waitIrq(10);
    src = 8'h10;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    turnOffIRQ = 1'b1;
    @(negedge clk);
    checkEq("raceIrqLow", {31'b0, irq}, 32'd0);
    readReg(2'd1, rd); checkEq("raceSetWins", {16'h0, rd}, 32'h10);
    turnOffIRQ = 1'b0;
    waitIrq(10);
    ackIrq();

    // Software trigger and non-default vector base
    writeReg(2'd0, 16'h00C0);
    writeReg(2'd2, 16'hABCD);
    expQ.push_back({32'hABCD_000C, 16'h4006});
    writeReg(2'd3, 16'h0040);
    waitIrq(10);
    ackIrq();
    expQ.push_back({32'hABCD_000E, 16'h8007});
    pulse(8'h80);
    waitIrq(10);
    ackIrq();

    // Asynchronous reset mid-request
    writeReg(2'd0, 16'h0001);
    expQ.push_back({32'hABCD_0000, 16'h0100});
    pulse(8'h01);
    waitIrq(10);
    #2 rst = 1'b0;
    #1;
    checkEq("asyncIrq", {31'b0, irq}, 32'd0);
    checkEq("asyncAddr", intAddr, 32'd0);
    checkEq("asyncData", {16'h0, intData}, 32'd0);
    readReg(2'd1, rd); checkEq("asyncPend", {16'h0, rd}, 32'h0);
    readReg(2'd2, rd); checkEq("asyncVec", {16'h0, rd}, 32'hF000);
    @(negedge clk);
    rst = 1'b1;
    cyc(4);
    checkEq("postRstIrq", {31'b0, irq}, 32'd0);
    checkEq("queueEmpty", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
